// File: rtl/spi_mem_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// spi_mem_ctrl_pkg : shared CPU/memory-handshake types and SPI SRAM constants
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package spi_mem_ctrl_pkg;

  typedef enum logic [1:0] {
    MEM_NOP   = 2'b00,
    MEM_READ  = 2'b01,
    MEM_WRITE = 2'b10
  } mem_ctrl_op_e;

  localparam logic [7:0] SPI_CMD_READ  = 8'h03;
  localparam logic [7:0] SPI_CMD_WRITE = 8'h02;
  localparam int         FRAME_LEN     = 32;

  // Whole transaction as one MSB-first word: opcode, 16-bit address, data byte.
  function automatic logic [FRAME_LEN-1:0] build_frame(input logic        is_write,
                                                       input logic [15:0] addr,
                                                       input logic [7:0]  wdata);
    return is_write ? {SPI_CMD_WRITE, addr, wdata} : {SPI_CMD_READ, addr, 8'h00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_mem_ctrl_if.sv
// -----------------------------------------------------------------------------
// spi_mem_ctrl_if : ctrl <-> memory controller request/response bundle
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

interface spi_mem_ctrl_if #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_BUS_WIDTH = 8
);
  import spi_mem_ctrl_pkg::*;

  mem_ctrl_op_e              mem_ctrl_op;
  logic [ADDR_WIDTH-1:0]     addr;
  logic [DATA_BUS_WIDTH-1:0] data_in;
  logic [DATA_BUS_WIDTH-1:0] data_out;
  logic                      mem_op_done;

  modport master (
    output mem_ctrl_op, addr, data_in,
    input  data_out, mem_op_done
  );

  modport slave (
    input  mem_ctrl_op, addr, data_in,
    output data_out, mem_op_done
  );

endinterface

`default_nettype wire

// File: rtl/spi_mem_ctrl_shifter.sv
// -----------------------------------------------------------------------------
// spi_shifter : 32-bit TX frame shifter, 8-bit RX shifter, mode-0 SCLK phasing
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module spi_shifter
  import spi_mem_ctrl_pkg::*;
(
  input  logic                 clock_i,
  input  logic                 reset_ni,
  input  logic                 load_i,
  input  logic [FRAME_LEN-1:0] frame_i,
  input  logic                 run_i,
  input  logic                 spi_miso_i,
  output logic                 spi_sclk_o,
  output logic                 spi_mosi_o,
  output logic                 sample_o,
  output logic [7:0]           rx_next_o
);

  logic [FRAME_LEN-1:0] tx_q, tx_d;
  logic [7:0]           rx_q, rx_d;
  logic                 sclk_q, sclk_d;

  // SCLK itself is the phase bit: the high-to-low edge is the MISO sample point.
  assign sample_o   = run_i & sclk_q;
  assign rx_next_o  = {rx_q[6:0], spi_miso_i};
  assign spi_sclk_o = sclk_q;
  assign spi_mosi_o = tx_q[FRAME_LEN-1];

  always_comb begin
    tx_d   = tx_q;
    rx_d   = rx_q;
    sclk_d = sclk_q;
    if (load_i) begin
      tx_d   = frame_i;
      sclk_d = 1'b0;
    end else if (run_i) begin
      if (!sclk_q) begin
        sclk_d = 1'b1;
      end else begin
        sclk_d = 1'b0;
        tx_d   = {tx_q[FRAME_LEN-2:0], 1'b0};
        rx_d   = rx_next_o;
      end
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      tx_q   <= '0;
      rx_q   <= '0;
      sclk_q <= 1'b0;
    end else begin
      tx_q   <= tx_d;
      rx_q   <= rx_d;
      sclk_q <= sclk_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/spi_mem_ctrl.sv
// -----------------------------------------------------------------------------
// spi_mem_ctrl : one-byte READ/WRITE on a 23LC512-style SPI SRAM, 4-phase handshake
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module spi_mem_ctrl
  import spi_mem_ctrl_pkg::*;
#(
  parameter int DATA_BUS_WIDTH = 8,
  parameter int ADDR_WIDTH     = 16
) (
  input  logic          clock_i,
  input  logic          reset_ni,
  spi_mem_ctrl_if.slave bus,
  output logic          spi_cs_n_o,
  output logic          spi_sclk_o,
  output logic          spi_mosi_o,
  input  logic          spi_miso_i
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_XFER = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]                state_q, state_d;
  logic [4:0]                cnt_q, cnt_d;
  logic                      cs_n_q, cs_n_d;
  logic                      done_q, done_d;
  logic                      is_read_q, is_read_d;
  logic [DATA_BUS_WIDTH-1:0] data_out_q, data_out_d;

  logic                      load_w;
  logic                      sample_w;
  logic [7:0]                rx_next_w;
  logic [ADDR_WIDTH-1:0]     addr_w;
  logic [FRAME_LEN-1:0]      frame_w;

  assign addr_w  = bus.addr;
  assign frame_w = build_frame(bus.mem_ctrl_op == MEM_WRITE, 16'(addr_w), 8'(bus.data_in));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cs_n_d     = cs_n_q;
    done_d     = done_q;
    is_read_d  = is_read_q;
    data_out_d = data_out_q;
    load_w     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.mem_ctrl_op == MEM_READ || bus.mem_ctrl_op == MEM_WRITE) begin
          load_w    = 1'b1;
          state_d   = ST_XFER;
          cs_n_d    = 1'b0;
          cnt_d     = 5'd0;
          is_read_d = (bus.mem_ctrl_op == MEM_READ);
        end
      end
      ST_XFER: begin
        if (sample_w) begin
          cnt_d = cnt_q + 5'd1;
          // The 32nd sample edge also closes the frame.
          if (cnt_q == 5'd31) begin
            state_d = ST_DONE;
            cs_n_d  = 1'b1;
            done_d  = 1'b1;
            if (is_read_q) data_out_d = DATA_BUS_WIDTH'(rx_next_w);
          end
        end
      end
      ST_DONE: begin
        if (bus.mem_ctrl_op == MEM_NOP) begin
          state_d = ST_IDLE;
          done_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 5'd0;
      cs_n_q     <= 1'b1;
      done_q     <= 1'b0;
      is_read_q  <= 1'b0;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cs_n_q     <= cs_n_d;
      done_q     <= done_d;
      is_read_q  <= is_read_d;
      data_out_q <= data_out_d;
    end
  end

  spi_shifter u_shifter (
    .clock_i    (clock_i),
    .reset_ni   (reset_ni),
    .load_i     (load_w),
    .frame_i    (frame_w),
    .run_i      (state_q == ST_XFER),
    .spi_miso_i (spi_miso_i),
    .spi_sclk_o (spi_sclk_o),
    .spi_mosi_o (spi_mosi_o),
    .sample_o   (sample_w),
    .rx_next_o  (rx_next_w)
  );

  assign spi_cs_n_o      = cs_n_q;
  assign bus.data_out    = data_out_q;
  assign bus.mem_op_done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spi_mem_ctrl : directed + random transactions against an SPI SRAM model
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_spi_mem_ctrl;
  import spi_mem_ctrl_pkg::*;

  logic clk;
  logic rst_n;
  logic spi_cs_n, spi_sclk, spi_mosi, spi_miso;

  spi_mem_ctrl_if #(.ADDR_WIDTH(16), .DATA_BUS_WIDTH(8)) bus_if ();

  spi_mem_ctrl #(.DATA_BUS_WIDTH(8), .ADDR_WIDTH(16)) dut (
    .clock_i    (clk),
    .reset_ni   (rst_n),
    .bus        (bus_if),
    .spi_cs_n_o (spi_cs_n),
    .spi_sclk_o (spi_sclk),
    .spi_mosi_o (spi_mosi),
    .spi_miso_i (spi_miso)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // SRAM model: mode 0, samples MOSI on SCLK rise, drives MISO after SCLK fall.
  logic [7:0]  sram    [0:65535];
  logic [7:0]  ref_mem [0:65535];
  logic [31:0] sr_rx;
  logic [31:0] last_frame;
  logic [7:0]  sr_cmd;
  logic [15:0] sr_addr;
  int          sr_bits    = 0;
  int          sclk_rises = 0;
  int          cs_falls   = 0;

  initial begin
    forever begin
      @(posedge spi_sclk);
      sclk_rises++;
      if (!spi_cs_n) begin
        sr_rx = {sr_rx[30:0], spi_mosi};
        sr_bits++;
        if (sr_bits == 24) begin
          sr_cmd  = sr_rx[23:16];
          sr_addr = sr_rx[15:0];
        end
        if (sr_bits == 32) begin
          last_frame = sr_rx;
          if (sr_cmd == 8'h02) sram[sr_addr] = sr_rx[7:0];
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge spi_cs_n);
      cs_falls++;
      sr_bits = 0;
    end
  end

  initial begin
    spi_miso = 1'b0;
    forever begin
      @(negedge spi_sclk or negedge spi_cs_n);
      #1;
      if (sr_bits >= 24 && sr_bits < 32 && sr_cmd == 8'h03)
        spi_miso = sram[sr_addr][31 - sr_bits];
      else
        spi_miso = 1'($urandom);
    end
  end

  logic [7:0] exp_dout = 8'h00;

  // Caller is just after a rising edge; the next edge is the accept edge.
  task automatic do_op(input mem_ctrl_op_e op, input logic [15:0] a,
                       input logic [7:0] d, input int hold);
    int n;
    int rises0;
    int falls0;
    logic [31:0] exp_frame;
    exp_frame = (op == MEM_READ) ? {8'h03, a, 8'h00} : {8'h02, a, d};
    if (op == MEM_WRITE) ref_mem[a] = d;
    else exp_dout = ref_mem[a];
    rises0 = sclk_rises;
    bus_if.mem_ctrl_op = op;
    bus_if.addr        = a;
    bus_if.data_in     = d;
    for (n = 1; n <= 200; n++) begin
      @(posedge clk);
      #1;
      if (n == 1) check_val("accept_cs_n", 32'(spi_cs_n), 32'd0);
      if (bus_if.mem_op_done) break;
      bus_if.addr    = 16'($urandom);
      bus_if.data_in = 8'($urandom);
    end
    check_val("latency", n, 65);
    check_val("done_cs_n", 32'(spi_cs_n), 32'd1);
    check_val("done_sclk_mosi", {30'd0, spi_sclk, spi_mosi}, 32'd0);
    check_val("frame", last_frame, exp_frame);
    check_val("sclk_rises", sclk_rises - rises0, 32);
    check_val("data_out", 32'(bus_if.data_out), 32'(exp_dout));
    falls0 = cs_falls;
    repeat (hold) @(posedge clk);
    #1;
    if (hold > 0) begin
      check_val("hold_done", 32'(bus_if.mem_op_done), 32'd1);
      check_val("hold_no_cs", cs_falls - falls0, 0);
    end
    bus_if.mem_ctrl_op = MEM_NOP;
    @(posedge clk);
    #1;
    check_val("release_done", 32'(bus_if.mem_op_done), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      sram[i]    = 8'($urandom);
      ref_mem[i] = sram[i];
    end
    sram[16'h00FF]    = 8'h5C;
    ref_mem[16'h00FF] = 8'h5C;
    rst_n              = 1'b0;
    bus_if.mem_ctrl_op = MEM_NOP;
    bus_if.addr        = '0;
    bus_if.data_in     = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_outs", {28'd0, spi_cs_n, spi_sclk, spi_mosi, bus_if.mem_op_done}, 32'h8);
    check_val("reset_dout", 32'(bus_if.data_out), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    do_op(MEM_WRITE, 16'h1234, 8'hA5, 0);
    do_op(MEM_READ, 16'h00FF, 8'h00, 10);
    do_op(MEM_WRITE, 16'h0F0F, 8'h3C, 0);
    do_op(MEM_READ, 16'h1234, 8'h00, 0);

    for (int t = 0; t < 16; t++) begin
      logic [15:0] a;
      a = 16'($urandom_range(0, 7)) | (($urandom & 1) != 0 ? 16'hFF00 : 16'h0000);
      do_op(($urandom & 1) != 0 ? MEM_READ : MEM_WRITE, a, 8'($urandom),
            int'($urandom_range(0, 3)));
    end

    begin
      int r0;
      int f0;
      r0 = sclk_rises;
      f0 = cs_falls;
      bus_if.mem_ctrl_op = mem_ctrl_op_e'(2'b11);
      repeat (20) @(posedge clk);
      #1;
      check_val("illegal_cs_n", 32'(spi_cs_n), 32'd1);
      check_val("illegal_sclk", sclk_rises - r0, 0);
      check_val("illegal_cs_fall", cs_falls - f0, 0);
      bus_if.mem_ctrl_op = MEM_NOP;
      @(posedge clk);
      #1;
    end

    bus_if.mem_ctrl_op = MEM_WRITE;
    bus_if.addr        = 16'h4444;
    bus_if.data_in     = 8'h99;
    repeat (20) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("midreset_outs", {29'd0, spi_cs_n, spi_sclk, bus_if.mem_op_done}, 32'h4);
    check_val("midreset_dout", 32'(bus_if.data_out), 32'd0);
    exp_dout = 8'h00;
    bus_if.mem_ctrl_op = MEM_NOP;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_op(MEM_READ, 16'h4444, 8'h00, 0);
    do_op(MEM_READ, 16'h00FF, 8'h00, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
